// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird referee.
package flappy_pkg;

  localparam int unsigned ROWS      = 8;
  localparam int unsigned SCORE_MAX = 99;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} game_state_t;

  // Packs a small decimal value (0..99) as two BCD digits {tens, ones}.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(value / 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/flappy_referee_if.sv
// Signal bundle between the bird column / pipe source and the referee.
interface flappy_referee_if;
  import flappy_pkg::*;

  logic            press;
  logic [ROWS-1:0] bird_col;
  logic [ROWS-1:0] pipe_col;
  logic            active;
  logic            gameover;
  logic [3:0]      score_tens;
  logic [3:0]      score_ones;
  logic            score_pulse;

  // Column side: supplies player/column state, consumes game control.
  modport master (
    output press, bird_col, pipe_col,
    input  active, gameover, score_tens, score_ones, score_pulse
  );

  // Referee side.
  modport slave (
    input  press, bird_col, pipe_col,
    output active, gameover, score_tens, score_ones, score_pulse
  );

endinterface

// File: rtl/bcd_counter2.sv
// Two-digit BCD up-counter that saturates at SCORE_MAX; clear wins over inc.
module bcd_counter2
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  localparam logic [7:0] ScoreMaxBcd = to_bcd(SCORE_MAX);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  // Next-state: clear, else saturating BCD increment with ones->tens carry.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clear) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc && ({tens_q, ones_q} != ScoreMaxBcd)) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Score registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/flappy_referee.sv
// Game referee: run/stop FSM, collision and pipe-clear detection, BCD score.
module flappy_referee
  import flappy_pkg::*;
(
  input logic              clk,
  input logic              reset,
  flappy_referee_if.slave  bus
);

  game_state_t     state_q, state_d;
  logic            press_q;
  logic [ROWS-1:0] pipe_q;
  logic            armed_q, armed_d;
  logic            score_pulse_q;

  logic press_rise;
  logic pipe_exit;
  logic hit;
  logic score_clear;
  logic score_inc;

  assign press_rise = bus.press & ~press_q;
  assign pipe_exit  = (|pipe_q) & ~(|bus.pipe_col);
  // An empty bird column means the bird has dropped out of the bottom.
  assign hit        = (|(bus.bird_col & bus.pipe_col)) | (bus.bird_col == '0);

  // Next-state and score control; hit beats pipe_exit in the same cycle.
  always_comb begin
    state_d     = state_q;
    score_clear = 1'b0;
    score_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_rise) begin
          state_d     = PLAY;
          score_clear = 1'b1;
        end
      end
      PLAY: begin
        if (armed_q && hit) begin
          state_d = OVER;
        end else if (pipe_exit) begin
          score_inc = 1'b1;
        end
      end
      OVER: begin
        if (press_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Bird cells are still leaving reset during the first PLAY cycle.
    armed_d = (state_q == PLAY) && (state_d == PLAY);
  end

  // State, history and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      press_q       <= 1'b0;
      pipe_q        <= '0;
      armed_q       <= 1'b0;
      score_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      press_q       <= bus.press;
      pipe_q        <= bus.pipe_col;
      armed_q       <= armed_d;
      score_pulse_q <= score_inc;
    end
  end

  bcd_counter2 u_score (
    .clk   (clk),
    .reset (reset),
    .clear (score_clear),
    .inc   (score_inc),
    .tens  (bus.score_tens),
    .ones  (bus.score_ones)
  );

  assign bus.active      = (state_q != IDLE);
  assign bus.gameover    = (state_q == OVER);
  assign bus.score_pulse = score_pulse_q;

endmodule

// File: tb/tb_flappy_referee.sv
// Bench for flappy_referee: directed scenarios plus randomized play vs a game model.
module tb_flappy_referee;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  flappy_referee_if bus ();

  flappy_referee dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: game mode, cycles spent in PLAY, decimal score.
  localparam int MIdle = 0;
  localparam int MPlay = 1;
  localparam int MOver = 2;

  int         m_mode;
  int         m_play_cycles;
  int         m_score;
  bit         m_pulse;
  bit         m_press_prev;
  logic [7:0] m_pipe_prev;

  task automatic model_step(input logic r, input logic p, input logic [7:0] b,
                            input logic [7:0] pc);
    bit rise;
    bit collide;
    bit cleared;
    m_pulse = 1'b0;
    if (r) begin
      m_mode        = MIdle;
      m_score       = 0;
      m_play_cycles = 0;
      m_press_prev  = 1'b0;
      m_pipe_prev   = 8'h00;
      return;
    end
    rise    = p && !m_press_prev;
    collide = ((b & pc) != 8'h00) || (b == 8'h00);
    cleared = (m_pipe_prev != 8'h00) && (pc == 8'h00);
    case (m_mode)
      MIdle: begin
        if (rise) begin
          m_mode        = MPlay;
          m_score       = 0;
          m_play_cycles = 0;
        end
      end
      MPlay: begin
        if (m_play_cycles > 0 && collide) begin
          m_mode = MOver;
        end else begin
          if (cleared) begin
            if (m_score < 99) m_score++;
            m_pulse = 1'b1;
          end
          m_play_cycles++;
        end
      end
      default: if (rise) m_mode = MIdle;
    endcase
    m_press_prev = p;
    m_pipe_prev  = pc;
  endtask

  // One clock: drive inputs at the falling edge, sample 1 ns after the rising edge.
  task automatic tick(input logic r, input logic p, input logic [7:0] b, input logic [7:0] pc);
    @(negedge clk);
    reset        = r;
    bus.press    = p;
    bus.bird_col = b;
    bus.pipe_col = pc;
    model_step(r, p, b, pc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 8'h08, 8'h00);
    tick(1'b1, 1'b0, 8'h08, 8'h00);
    checks++;
    if (bus.active !== 1'b0 || bus.gameover !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: active=%b gameover=%b, required 0 0", bus.active, bus.gameover);
    end
    checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h00 || bus.score_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_score: score=%h pulse=%b, required 00 0",
               {bus.score_tens, bus.score_ones}, bus.score_pulse);
    end
    tick(1'b0, 1'b0, 8'h08, 8'h00);
    checks++;
    if (bus.active !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: active=%b, required 0", bus.active);
    end
    tick(1'b0, 1'b1, 8'h08, 8'h00);
    checks++;
    if (bus.active !== 1'b1 || bus.gameover !== 1'b0) begin
      errors++;
      $display("FAIL start: active=%b gameover=%b, required 1 0", bus.active, bus.gameover);
    end
    tick(1'b0, 1'b0, 8'h08, 8'h00);
  endtask

  task automatic test_score_one();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 8'h08, 8'hF0);
      pulses += int'(bus.score_pulse);
    end
    tick(1'b0, 1'b0, 8'h08, 8'h00);
    pulses += int'(bus.score_pulse);
    checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h01 || bus.score_pulse !== 1'b1) begin
      errors++;
      $display("FAIL first_point: score=%h pulse=%b, required 01 1",
               {bus.score_tens, bus.score_ones}, bus.score_pulse);
    end
    tick(1'b0, 1'b0, 8'h08, 8'h00);
    pulses += int'(bus.score_pulse);
    checks++;
    if (pulses != 1 || bus.gameover !== 1'b0) begin
      errors++;
      $display("FAIL one_pulse: pulses=%0d gameover=%b, required 1 0", pulses, bus.gameover);
    end
  endtask

  task automatic test_hit();
    tick(1'b0, 1'b0, 8'h10, 8'hF0);
    checks++;
    if (bus.gameover !== 1'b1 || bus.active !== 1'b1) begin
      errors++;
      $display("FAIL pipe_hit: gameover=%b active=%b, required 1 1", bus.gameover, bus.active);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 8'h08, 8'hF0);
      tick(1'b0, 1'b0, 8'h08, 8'h00);
    end
    checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h01 || bus.gameover !== 1'b1) begin
      errors++;
      $display("FAIL over_frozen: score=%h gameover=%b, required 01 1",
               {bus.score_tens, bus.score_ones}, bus.gameover);
    end
  endtask

  task automatic test_fall();
    tick(1'b0, 1'b1, 8'h08, 8'h00);
    checks++;
    if (bus.active !== 1'b0 || {bus.score_tens, bus.score_ones} !== 8'h01) begin
      errors++;
      $display("FAIL over_to_idle: active=%b score=%h, required 0 01",
               bus.active, {bus.score_tens, bus.score_ones});
    end
    tick(1'b0, 1'b0, 8'h08, 8'h00);
    tick(1'b0, 1'b1, 8'h08, 8'h00);
    checks++;
    if (bus.active !== 1'b1 || {bus.score_tens, bus.score_ones} !== 8'h00) begin
      errors++;
      $display("FAIL restart: active=%b score=%h, required 1 00",
               bus.active, {bus.score_tens, bus.score_ones});
    end
    // Empty column in the first PLAY cycle must be ignored.
    tick(1'b0, 1'b0, 8'h00, 8'hF0);
    checks++;
    if (bus.gameover !== 1'b0) begin
      errors++;
      $display("FAIL unarmed: gameover=%b, required 0", bus.gameover);
    end
    tick(1'b0, 1'b0, 8'h08, 8'h00);
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (bus.gameover !== 1'b1 || {bus.score_tens, bus.score_ones} !== 8'h01) begin
      errors++;
      $display("FAIL fall: gameover=%b score=%h, required 1 01",
               bus.gameover, {bus.score_tens, bus.score_ones});
    end
    tick(1'b0, 1'b1, 8'h08, 8'h00);
    tick(1'b0, 1'b0, 8'h08, 8'h00);
    checks++;
    if (bus.active !== 1'b0 || {bus.score_tens, bus.score_ones} !== 8'h01) begin
      errors++;
      $display("FAIL idle_score_held: active=%b score=%h, required 0 01",
               bus.active, {bus.score_tens, bus.score_ones});
    end
    tick(1'b0, 1'b1, 8'h08, 8'h00);
    checks++;
    if (bus.active !== 1'b1 || {bus.score_tens, bus.score_ones} !== 8'h00) begin
      errors++;
      $display("FAIL start_clears: active=%b score=%h, required 1 00",
               bus.active, {bus.score_tens, bus.score_ones});
    end
    tick(1'b0, 1'b0, 8'h08, 8'h00);
  endtask

  task automatic test_saturate();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0, 8'h08, 8'hF0);
      pulses += int'(bus.score_pulse);
      tick(1'b0, 1'b0, 8'h08, 8'h00);
      pulses += int'(bus.score_pulse);
      if (i == 8 || i == 9 || i == 97 || i == 98 || i == 99) begin
        logic [7:0] want;
        want = (i == 8) ? 8'h09 : (i == 9) ? 8'h10 : (i == 97) ? 8'h98 : 8'h99;
        checks++;
        if ({bus.score_tens, bus.score_ones} !== want) begin
          errors++;
          $display("FAIL bcd_step_%0d: score=%h, required %h", i + 1,
                   {bus.score_tens, bus.score_ones}, want);
        end
      end
    end
    checks++;
    if (pulses != 100 || bus.gameover !== 1'b0) begin
      errors++;
      $display("FAIL sat_pulses: pulses=%0d gameover=%b, required 100 0", pulses, bus.gameover);
    end
  endtask

  task automatic test_press_held();
    tick(1'b1, 1'b0, 8'h08, 8'h00);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 8'h08, 8'h00);
    checks++;
    if (bus.active !== 1'b1 || bus.gameover !== 1'b0) begin
      errors++;
      $display("FAIL held_press: active=%b gameover=%b, required 1 0", bus.active, bus.gameover);
    end
    tick(1'b0, 1'b0, 8'h08, 8'h00);
    tick(1'b1, 1'b0, 8'h08, 8'h00);
    checks++;
    if (bus.active !== 1'b0 || {bus.score_tens, bus.score_ones} !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: active=%b score=%h, required 0 00",
               bus.active, {bus.score_tens, bus.score_ones});
    end
  endtask

  task automatic test_random();
    logic       r;
    logic       p;
    logic [7:0] b;
    logic [7:0] pc;
    logic [7:0] want;
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      p  = ($urandom_range(0, 5) == 0);
      b  = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      pc = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      tick(r, p, b, pc);
      want = 8'(((m_score / 10) << 4) | (m_score % 10));
      checks++;
      if (bus.active !== (m_mode != MIdle) || bus.gameover !== (m_mode == MOver)) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: active=%b gameover=%b, required %b %b", i, bus.active,
                 bus.gameover, (m_mode != MIdle), (m_mode == MOver));
      end
      checks++;
      if ({bus.score_tens, bus.score_ones} !== want || bus.score_pulse !== m_pulse) begin
        errors++;
        $display("FAIL rand_score@%0d: score=%h pulse=%b, required %h %b", i,
                 {bus.score_tens, bus.score_ones}, bus.score_pulse, want, m_pulse);
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.press    = 1'b0;
    bus.bird_col = 8'h08;
    bus.pipe_col = 8'h00;
    test_reset();
    test_score_one();
    test_hit();
    test_fall();
    test_saturate();
    test_press_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
